// File: rtl/spi_slave.sv
// SPI mode-0 slave with synchronized SCLK/CS/MOSI, byte-wise tx holding register and rx output.
// Optional overrun detection (rx_overrun / rx_ack) is compiled in with SPI_SLAVE_OVERRUN_EN.
module spi_slave (
   input  logic       clk,
   input  logic       rst,
   input  logic       SCLK,
   input  logic       CS,
   input  logic       MOSI,
   output logic       MISO,
   input  logic [7:0] tx_data,
   input  logic       tx_load,
   output logic       tx_pending,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy
`ifdef SPI_SLAVE_OVERRUN_EN
   ,
   input  logic       rx_ack,
   output logic       rx_overrun
`endif
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t     state_q, state_d;
   logic       cs_meta, cs_sync, cs_dly;
   logic       sclk_meta, sclk_sync, sclk_dly;
   logic       mosi_meta, mosi_sync;
   logic [1:0] flush_q;
   logic       armed;
   logic [7:0] hold_reg, tx_shift, rx_shift, load_byte;
   logic [2:0] bit_cnt, next_cnt;
   logic       cs_fall, cs_rise, sclk_rise, sclk_fall;
   logic       do_load, do_capture, do_shift, do_byte_done, do_abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_meta   <= 1'b1;
         cs_sync   <= 1'b1;
         cs_dly    <= 1'b1;
         sclk_meta <= 1'b0;
         sclk_sync <= 1'b0;
         sclk_dly  <= 1'b0;
         mosi_meta <= 1'b0;
         mosi_sync <= 1'b0;
         flush_q   <= 2'b00;
         armed     <= 1'b0;
      end else begin
         cs_meta   <= CS;
         cs_sync   <= cs_meta;
         cs_dly    <= cs_sync;
         sclk_meta <= SCLK;
         sclk_sync <= sclk_meta;
         sclk_dly  <= sclk_sync;
         mosi_meta <= MOSI;
         mosi_sync <= mosi_meta;
         flush_q   <= {flush_q[0], 1'b1};
         // A CS already low when reset releases must not look like a new falling edge.
         armed     <= armed | (flush_q[1] & cs_sync);
      end
   end

   assign cs_fall   = armed & cs_dly & ~cs_sync;
   assign cs_rise   = ~cs_dly & cs_sync;
   assign sclk_rise = sclk_sync & ~sclk_dly;
   assign sclk_fall = ~sclk_sync & sclk_dly;
   assign load_byte = tx_pending ? hold_reg : 8'h00;
   assign next_cnt  = bit_cnt - 3'd1;
   assign busy      = (state_q == ACTIVE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      do_load      = 1'b0;
      do_capture   = 1'b0;
      do_shift     = 1'b0;
      do_byte_done = 1'b0;
      do_abort     = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d = ACTIVE;
               do_load = 1'b1;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               state_d  = IDLE;
               do_abort = 1'b1;
            end else begin
               do_capture = sclk_rise;
               if (sclk_fall) begin
                  if (bit_cnt == 3'd0) begin
                     do_byte_done = 1'b1;
                     do_load      = 1'b1;
                  end else begin
                     do_shift = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_reg   <= 8'h00;
         tx_pending <= 1'b0;
         tx_shift   <= 8'h00;
         rx_shift   <= 8'h00;
         rx_data    <= 8'h00;
         rx_valid   <= 1'b0;
         bit_cnt    <= 3'd7;
         MISO       <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (do_load) begin
            tx_shift   <= load_byte;
            MISO       <= load_byte[7];
            tx_pending <= 1'b0;
            bit_cnt    <= 3'd7;
         end
         // A coincident write lands after the load, so it stays pending for the next byte.
         if (tx_load) begin
            hold_reg   <= tx_data;
            tx_pending <= 1'b1;
         end
         if (do_capture) rx_shift[bit_cnt] <= mosi_sync;
         if (do_shift) begin
            bit_cnt <= next_cnt;
            MISO    <= tx_shift[next_cnt];
         end
         if (do_byte_done) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
         end
         if (do_abort) begin
            bit_cnt <= 3'd7;
            MISO    <= 1'b0;
         end
      end
   end

`ifdef SPI_SLAVE_OVERRUN_EN
   logic rx_unread;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_unread  <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         if (rx_ack) begin
            rx_unread  <= 1'b0;
            rx_overrun <= 1'b0;
         end
         if (rx_valid) begin
            rx_unread <= 1'b1;
            if (rx_unread && !rx_ack) rx_overrun <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 clk  input  1  system clock, all state on rising edge; must be at least 8x SCLK frequency.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 SCLK  input  1  serial clock from master, idle low (mode 0), asynchronous to clk.
REQ-004 CS  input  1  chip select from master, active low, asynchronous to clk.
REQ-005 MOSI  input  1  serial data from master, MSB first.
REQ-006 MISO  output  1  serial data to master, MSB first; driven 0 (no tristate) while deselected.
REQ-007 tx_data  input  8  byte to return on the next frame.
REQ-008 tx_load  input  1  one-cycle strobe; writes tx_data into the holding register.
REQ-009 tx_pending  output  1  holding register contains a byte not yet sent.
REQ-010 rx_data  output  8  last complete received byte.
REQ-011 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-012 busy  output  1  high while a frame is selected (state ACTIVE).

Function
REQ-013 SCLK, CS and MOSI shall each pass a 2-flop synchronizer; edge detection uses the synchronized value and its 1-cycle delayed copy.
REQ-014 States: IDLE (CS high) and ACTIVE; IDLE->ACTIVE on synchronized CS falling edge; ACTIVE->IDLE on synchronized CS rising edge, from any bit position.
REQ-015 On IDLE->ACTIVE the shift-out register loads the holding register if tx_pending=1, else 8'h00; tx_pending clears the same cycle; MISO = bit 7 of the loaded byte from the next cycle; bit counter = 7.
REQ-016 On a synchronized SCLK rising edge in ACTIVE, the synchronized MOSI shall be stored into rx shift register bit [bit counter].
REQ-017 On a synchronized SCLK falling edge in ACTIVE with bit counter > 0, the counter decrements and MISO presents the next lower tx bit.
REQ-018 On the SCLK falling edge with bit counter = 0: rx_data <= assembled byte, rx_valid pulses 1 cycle, counter wraps to 7, and the next tx byte is loaded per REQ-015 (continuous multi-byte frames under one CS).
REQ-019 CS rising before 8 bits are complete (abort) shall discard the partial byte: no rx_valid, rx_data unchanged, counter reset to 7, MISO <= 0.
REQ-020 Timing contract: SCLK high and low phases each >= 4 clk periods; MISO settles within 4 clk cycles of the SCLK falling edge.
REQ-021 tx_load coincident with a byte load (REQ-015/018): the load uses the old holding value; the new tx_data is stored and tx_pending stays 1.
REQ-022 tx_load while tx_pending=1 overwrites the holding register (last write wins).
REQ-023 SCLK edges while CS is high shall be ignored.

Reset
REQ-024 rst high shall immediately force: state IDLE, MISO=0, busy=0, rx_data=8'h00, rx_valid=0, tx_pending=0, holding register=8'h00, counter=7, synchronizer flops=CS 1 / SCLK 0 / MOSI 0.
REQ-025 Reset during ACTIVE abandons the frame; after release the block waits for a new CS falling edge, even if CS is already low.

Configuration
REQ-026 Macro SPI_SLAVE_OVERRUN_EN: when defined, adds output rx_overrun (1 bit) and input rx_ack (1 bit); rx_ack clears an internal rx_unread flag set by rx_valid; rx_valid while rx_unread=1 sets sticky rx_overrun, which clears only on rst or on rx_ack; rx_data still updates.
REQ-027 Without SPI_SLAVE_OVERRUN_EN those ports and that logic shall not exist; behaviour is otherwise identical.

Verification
REQ-028 tx_load with 8'hA5, master sends 8'h3C with SCLK half-period 5 clk -> MISO bits 1,0,1,0,0,1,0,1; rx_data=8'h3C with one rx_valid pulse; tx_pending 1->0 at CS fall.
REQ-029 No tx_load, master sends 8'hFF -> MISO all 0, rx_data=8'hFF.
REQ-030 Two bytes under one CS (8'h12, 8'h34), holding reloaded with 8'h99 between bytes -> two rx_valid pulses, second byte returns 8'h99.
REQ-031 CS raised after 5 bits -> no rx_valid, rx_data unchanged, busy=0; next full frame 8'h81 received correctly.
REQ-032 rst asserted mid-byte -> all outputs at REQ-024 values on the same cycle; a subsequent frame works.
REQ-033 With SPI_SLAVE_OVERRUN_EN, two frames without rx_ack -> rx_overrun=1 after the second; rx_ack -> rx_overrun=0.
